bloonstd1_soc_keycode_fifo: RTL
===============================

BLOONSTD1_SOC_KEYCODE_FIFO -- requirements
Module: bloonstd1_soc_keycode_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, keycode width in bits; legal range 1..32.
REQ-002 Parameter DEPTH_LOG2, default 3, FIFO depth = 2**DEPTH_LOG2 entries; legal range 1..8.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 address  in  2  Avalon-MM word address.
REQ-006 chipselect  in  1  Avalon-MM select.
REQ-007 write_n  in  1  Avalon-MM write strobe, active-low.
REQ-008 writedata  in  32  Avalon-MM write data.
REQ-009 readdata  out  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-010 out_data  out  DATA_WIDTH  FIFO head entry, show-ahead.
REQ-011 out_valid  out  1  high when FIFO non-empty.
REQ-012 out_ready  in  1  consumer accept; pop = out_valid & out_ready.
REQ-013 out_port  out  DATA_WIDTH  registered copy of last popped keycode.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Write = chipselect & ~write_n; reads have no side effects.
REQ-016 Addr 0 write: push writedata[DATA_WIDTH-1:0]; addr 0 read: out_data zero-extended (0 when empty).
REQ-017 Addr 1 read: status; bits [DEPTH_LOG2:0] count, bit 16 empty, bit 17 full, bit 18 overflow, other bits 0.
REQ-018 Addr 1 write: writedata[18]=1 clears overflow (write-1-to-clear); other bits ignored.
REQ-019 Addr 2 write: bit 0 flush (self-clearing, reads 0), bit 1 irq_ne_en, bit 2 irq_ovf_en; read returns {irq_ovf_en, irq_ne_en, 0} in bits [2:0].
REQ-020 Addr 3 read: out_port zero-extended; addr 3 write ignored.
REQ-021 Count width DEPTH_LOG2+1; read/write pointers DEPTH_LOG2 bits, wrap modulo DEPTH.
REQ-022 Push when not full: entry written at wptr, wptr+1, count+1, visible on out_data next cycle if FIFO was empty.
REQ-023 Push when full and no pop same cycle: data discarded, count unchanged, overflow set to 1 next cycle.
REQ-024 Push when full with pop same cycle: push accepted, count unchanged, overflow not set.
REQ-025 Push and pop same cycle, not full: both occur, count unchanged.
REQ-026 Pop: rptr+1, count-1, out_port <= out_data on same edge; out_ready while empty has no effect.
REQ-027 Flush: count, wptr, rptr -> 0 next cycle; concurrent pop ignored; out_port, overflow, enables unchanged.
REQ-028 Overflow-clear and new overflow in same cycle cannot coincide (single port); overflow stays 1 until cleared or reset.
REQ-029 irq = (irq_ne_en & out_valid) | (irq_ovf_en & overflow), combinational from registers.
REQ-030 out_valid = (count != 0); full = (count == DEPTH).

Reset
REQ-031 On reset_n low, immediately: count, pointers, out_port, overflow, irq_ne_en, irq_ovf_en -> 0; out_valid 0, irq 0.
REQ-032 FIFO storage need not be reset; out_data and addr 0 read shall be 0 while empty regardless.
REQ-033 Reset asserted mid-operation discards all entries; no pop or push completes on that edge.

Verification
REQ-034 Reset, write 0x1C to addr 0, out_ready=0 -> out_valid=1, out_data=0x1C, status count=1, empty=0.
REQ-035 Fill 8 writes (0x01..0x08), 9th write 0x09 -> full=1, overflow=1, pop sequence 0x01..0x08, out_port ends 0x08.
REQ-036 FIFO full, out_ready=1 while writing 0x55 -> count stays 8, overflow 0, 0x55 popped last after 7 more pops.
REQ-037 Write addr2=0x2 with FIFO empty -> irq 0; push 0x1A -> irq 1; pop -> irq 0; set overflow with addr2=0x4 -> irq 1; write addr1 bit18 -> irq 0.
REQ-038 3 entries queued, write addr2=0x1 -> count 0, out_valid 0, out_port holds prior value; next push wraps pointers correctly.
REQ-039 Repeat REQ-035 with DATA_WIDTH=4, DEPTH_LOG2=1 -> writedata[3:0] only, full at 2, readdata upper bits 0.

Source files
------------

// File: rtl/bloonstd1_soc_keycode_fifo.sv
// -----------------------------------------------------------------------------
// bloonstd1_soc_keycode_fifo
//
// Keycode FIFO with an Avalon-MM slave for the CPU side and a show-ahead
// valid/ready stream for the consumer side.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0] word address (0 data, 1 status, 2 control, 3 out_port)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   readdata    out  [31:0] read data, combinational from address
//   out_data    out  [DATA_WIDTH-1:0] FIFO head (0 when empty)
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer accept; pop = out_valid & out_ready
//   out_port    out  [DATA_WIDTH-1:0] last popped keycode
//   irq         out  level interrupt (non-empty and/or overflow, per enables)
//
// Register map:
//   0  W: push writedata[DATA_WIDTH-1:0]      R: head entry, zero-extended
//   1  W: bit 18 = 1 clears overflow          R: count / empty(16) / full(17) / overflow(18)
//   2  W: bit0 flush, bit1 irq_ne_en, bit2 irq_ovf_en   R: {irq_ovf_en, irq_ne_en, 0}
//   3  W: ignored                             R: out_port, zero-extended
// -----------------------------------------------------------------------------
module bloonstd1_soc_keycode_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_PORT   = 2'd3;

   // Storage is deliberately left unreset; out_data masks it while empty.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [CW-1:0]         count_q,      count_d;
   logic [DEPTH_LOG2-1:0] wptr_q,       wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q,       rptr_d;
   logic [DATA_WIDTH-1:0] out_port_q,   out_port_d;
   logic                  overflow_q,   overflow_d;
   logic                  irq_ne_en_q,  irq_ne_en_d;
   logic                  irq_ovf_en_q, irq_ovf_en_d;

   logic bus_wr;
   logic push_req;
   logic push_ok;
   logic pop;
   logic flush;
   logic full;

   // writedata bits above the keycode and outside the control fields are
   // don't-care; fold them into one sink so the intent is explicit.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   assign full      = (count_q == FULL_COUNT);
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rptr_q] : '0;
   assign out_port  = out_port_q;

   assign bus_wr   = chipselect & ~write_n;
   assign push_req = bus_wr & (address == ADDR_DATA);
   assign flush    = bus_wr & (address == ADDR_CTRL) & writedata[0];
   assign pop      = out_valid & out_ready;
   // A full FIFO still accepts a push when a pop frees a slot on the same edge.
   assign push_ok  = push_req & (~full | pop);

   assign irq = (irq_ne_en_q & out_valid) | (irq_ovf_en_q & overflow_q);

   always_comb begin
      count_d      = count_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      out_port_d   = out_port_q;
      overflow_d   = overflow_q;
      irq_ne_en_d  = irq_ne_en_q;
      irq_ovf_en_d = irq_ovf_en_q;

      if (flush) begin
         // A flush and a push cannot coincide (single bus port); any pop on
         // this edge is dropped so out_port keeps its previous value.
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         if (pop) begin
            rptr_d     = rptr_q + PTR_ONE;
            out_port_d = out_data;
         end
         if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      if (push_req & full & ~pop) begin
         overflow_d = 1'b1;
      end else if (bus_wr & (address == ADDR_STATUS) & writedata[18]) begin
         overflow_d = 1'b0;
      end

      if (bus_wr & (address == ADDR_CTRL)) begin
         irq_ne_en_d  = writedata[1];
         irq_ovf_en_d = writedata[2];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q      <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         out_port_q   <= '0;
         overflow_q   <= 1'b0;
         irq_ne_en_q  <= 1'b0;
         irq_ovf_en_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         out_port_q   <= out_port_d;
         overflow_q   <= overflow_d;
         irq_ne_en_q  <= irq_ne_en_d;
         irq_ovf_en_q <= irq_ovf_en_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wptr_q] <= writedata[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata[DATA_WIDTH-1:0] = out_data;
         ADDR_STATUS: begin
            readdata[CW-1:0] = count_q;
            readdata[16]     = ~out_valid;
            readdata[17]     = full;
            readdata[18]     = overflow_q;
         end
         ADDR_CTRL:   readdata[2:1] = {irq_ovf_en_q, irq_ne_en_q};
         ADDR_PORT:   readdata[DATA_WIDTH-1:0] = out_port_q;
      endcase
   end

endmodule
